// File: rtl/seq_player_if.sv
// seq_player_if
//   Bundles the control, table-write and display signals of seq_player.
//   Parameters mirror the player: WIDTH (bits per value), DEPTH (table
//   entries), DIGITS (packed BCD digits).
//
//   Signal summary
//     run, step, up, rate, len, pingpong   control from the master
//     wr_en, wr_addr, wr_data              table write port from the master
//     pos, value, bcd, wrap                display outputs from the player
//     dbg_run_state, dbg_pcnt              observation of FSM state and prescaler
//
//   Handshake: there are no valid/ready pairs on this bus. Every input is
//   sampled on each posedge of the step clock; wr_en qualifies wr_addr/wr_data
//   on the edge where it is high and is never back-pressured.
interface seq_player_if #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int DIGITS = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                  run;
    logic                  step;
    logic                  up;
    logic [1:0]            rate;
    logic [AW:0]           len;
    logic                  pingpong;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [WIDTH-1:0]      wr_data;

    logic [AW-1:0]         pos;
    logic [WIDTH-1:0]      value;
    logic [4*DIGITS-1:0]   bcd;
    logic                  wrap;
    logic                  dbg_run_state;
    logic [1:0]            dbg_pcnt;

    modport master (
        output run, step, up, rate, len, pingpong,
        output wr_en, wr_addr, wr_data,
        input  pos, value, bcd, wrap, dbg_run_state, dbg_pcnt
    );

    modport slave (
        input  run, step, up, rate, len, pingpong,
        input  wr_en, wr_addr, wr_data,
        output pos, value, bcd, wrap, dbg_run_state, dbg_pcnt
    );
endinterface

// File: rtl/seq_player.sv
// seq_player
//   Steps through a writable table of DEPTH values on clk_500ms at a
//   programmable rate and direction, presenting the current entry in binary
//   and as DIGITS packed BCD digits for the seven-segment decoders.
//
//   Ports
//     clk_500ms  in   step clock (2 Hz tick domain)
//     reset      in   asynchronous, active-high
//     bus        seq_player_if.slave
//                  in : run, step, up, rate, len, pingpong, wr_en, wr_addr, wr_data
//                  out: pos, value, bcd, wrap, dbg_run_state, dbg_pcnt
//
//   Configuration
//     SEQ_PLAYER_PINGPONG_EN  when defined, pingpong=1 bounces at the ends of
//                             the active length instead of wrapping. When
//                             undefined, pingpong is ignored.
module seq_player #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int DIGITS = 2
) (
    input  logic         clk_500ms,
    input  logic         reset,
    seq_player_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SHW = WIDTH + 4 * DIGITS;

    localparam logic [AW:0]    LEN_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    LEN_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0]  POS_ONE = AW'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [1:0]        pcnt, pcnt_next;
    logic              advance;
    logic              run_tick;

    logic [WIDTH-1:0]  table_q [DEPTH];
    logic [AW-1:0]     pos_q, pos_next;
    logic [WIDTH-1:0]  value_q, value_next;
    logic              wrap_q, wrap_next;

    logic [AW:0]       eff_len;
    logic [AW:0]       last;
    logic [AW:0]       last_m1;
    logic [AW:0]       pos_ext;
    logic              wr_ok;
    logic              dir_eff;
    logic              dir_next;
    logic              bounce;

    logic [SHW-1:0]    sh;

    // Active length: 0 or anything past DEPTH selects the full table.
    assign eff_len = (bus.len == '0 || bus.len > LEN_MAX) ? LEN_MAX : bus.len;
    assign last    = eff_len - LEN_ONE;
    assign last_m1 = last - LEN_ONE;
    assign pos_ext = {1'b0, pos_q};

    // Writes outside a non-power-of-two table are dropped.
    assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < LEN_MAX);

    // Using >= lets a rate lowered mid-count fire on the very next edge.
    assign run_tick = (pcnt >= bus.rate);

`ifdef SEQ_PLAYER_PINGPONG_EN
    // dir_valid_q marks that dir_q holds a real direction; straight after
    // reset the bounce direction is taken from the up input.
    logic dir_q;
    logic dir_valid_q;

    assign bounce  = bus.pingpong;
    assign dir_eff = (bus.pingpong && dir_valid_q) ? dir_q : bus.up;

    always_ff @(posedge clk_500ms or posedge reset) begin
        if (reset) begin
            dir_q       <= 1'b1;
            dir_valid_q <= 1'b0;
        end else begin
            dir_q       <= dir_next;
            dir_valid_q <= 1'b1;
        end
    end
`else
    logic unused_pingpong;

    assign unused_pingpong = bus.pingpong;
    assign bounce          = 1'b0;
    assign dir_eff         = bus.up;
`endif

    // Run/idle FSM with the rate prescaler. Step sources: prescaler terminal
    // while running, the step input while idle.
    always_ff @(posedge clk_500ms or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            pcnt  <= 2'd0;
        end else begin
            state <= state_next;
            pcnt  <= pcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        pcnt_next  = pcnt;
        advance    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.run) begin
                    state_next = S_RUN;
                    advance    = run_tick;
                    pcnt_next  = run_tick ? 2'd0 : pcnt + 2'd1;
                end else begin
                    pcnt_next  = 2'd0;
                    advance    = bus.step;
                end
            end
            S_RUN: begin
                if (bus.run) begin
                    advance    = run_tick;
                    pcnt_next  = run_tick ? 2'd0 : pcnt + 2'd1;
                end else begin
                    state_next = S_IDLE;
                    pcnt_next  = 2'd0;
                    advance    = bus.step;
                end
            end
            default: begin
                state_next = S_IDLE;
                pcnt_next  = 2'd0;
            end
        endcase
    end

    // Position update. Out-of-range positions (length shrunk underneath us)
    // are handled first so both wrap and bounce modes recover the same way.
    always_comb begin
        pos_next  = pos_q;
        wrap_next = 1'b0;
        dir_next  = dir_eff;
        if (advance) begin
            if (pos_ext >= eff_len) begin
                pos_next  = dir_eff ? '0 : last[AW-1:0];
                wrap_next = 1'b1;
            end else if (eff_len == LEN_ONE) begin
                pos_next  = '0;
                wrap_next = 1'b1;
            end else if (bounce && dir_eff && pos_ext == last) begin
                pos_next  = last_m1[AW-1:0];
                dir_next  = 1'b0;
                wrap_next = 1'b1;
            end else if (bounce && !dir_eff && pos_q == '0) begin
                pos_next  = POS_ONE;
                dir_next  = 1'b1;
                wrap_next = 1'b1;
            end else if (dir_eff) begin
                if (pos_ext == last) begin
                    pos_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    pos_next  = pos_q + POS_ONE;
                end
            end else begin
                if (pos_q == '0) begin
                    pos_next  = last[AW-1:0];
                    wrap_next = 1'b1;
                end else begin
                    pos_next  = pos_q - POS_ONE;
                end
            end
        end
    end

    // A write landing on the entry being loaded this edge is forwarded so
    // value never shows the stale table content.
    always_comb begin
        if (wr_ok && bus.wr_addr == pos_next) begin
            value_next = bus.wr_data;
        end else begin
            value_next = table_q[pos_next];
        end
    end

    always_ff @(posedge clk_500ms or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= WIDTH'((i + 1) * 5);
            end
        end else if (wr_ok) begin
            table_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk_500ms or posedge reset) begin
        if (reset) begin
            pos_q   <= '0;
            value_q <= WIDTH'(5);
            wrap_q  <= 1'b0;
        end else begin
            pos_q   <= pos_next;
            value_q <= value_next;
            wrap_q  <= wrap_next;
        end
    end

    // Binary to BCD by shift-and-add-3 over the value bits.
    always_comb begin
        sh = '0;
        sh[WIDTH-1:0] = value_q;
        for (int i = 0; i < WIDTH; i++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (sh[WIDTH + 4 * d +: 4] >= 4'd5) begin
                    sh[WIDTH + 4 * d +: 4] = sh[WIDTH + 4 * d +: 4] + 4'd3;
                end
            end
            sh = sh << 1;
        end
    end

    assign bus.pos           = pos_q;
    assign bus.value         = value_q;
    assign bus.bcd           = sh[WIDTH +: 4 * DIGITS];
    assign bus.wrap          = wrap_q;
    assign bus.dbg_run_state = (state == S_RUN);
    assign bus.dbg_pcnt      = pcnt;
endmodule

// File: doc/seq_player.md
# seq_player

Parametrised sequence player for the seven-segment demo path. It steps through a writable table of `DEPTH` values at a programmable rate and direction, clocked by `clk_500ms`. It presents the current value in binary and as `DIGITS` packed BCD digits, ready for the existing hex/7-seg decoders. It replaces the fixed 8-entry, fixed-rate sequence logic. It adds the following:
- runtime table load
- variable length
- rate division
- single-step
- optional ping-pong mode

## Interface
Parameters:
- `WIDTH`, 4: bits per table value.
- `DEPTH`, 8: table entries; `AW = $clog2(DEPTH)`.
- `DIGITS`, 2: BCD digits; must satisfy `10**DIGITS > 2**WIDTH-1`.

Ports:
- `clk_500ms`  in  1  step clock (2 Hz tick domain).
- `reset`  in  1  asynchronous, active-high.
- `run`  in  1  1 = auto-advance at the selected rate.
- `step`  in  1  while `run`=0, advance one position on this edge.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `rate`  in  2  advance every `rate+1` edges (1..4).
- `len`  in  AW+1  active length; 0 or >`DEPTH` means `DEPTH`.
- `pingpong`  in  1  bounce mode (only with macro, see Configuration).
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  WIDTH  write data.
- `pos`  out  AW  current table index.
- `value`  out  WIDTH  table[pos], registered.
- `bcd`  out  4*DIGITS  BCD of `value`, digit 0 in bits [3:0].
- `wrap`  out  1  one-edge pulse when a step wraps or bounces.

## Operation
- Table reset contents: entry i = ((i+1)*5) mod 2**WIDTH. With defaults: 5,10,15,4,9,14,3,8.
- Writes:
  - Occur on any edge with `wr_en`=1, independent of `run`.
  - A write to the address being loaded into `value` on that edge is forwarded, so `value` shows `wr_data`.
- Rate prescaler `pcnt` (2 bits):
  - While `run`=1, `pcnt` increments each edge.
  - When `pcnt >= rate`, a step occurs and `pcnt` clears. Using >= handles a `rate` decrease mid-count.
  - While `run`=0, `pcnt` holds at 0.
- Step sources:
  - Prescaler terminal with `run`=1.
  - `step`=1 with `run`=0; this takes effect every edge `step` is high.
  - `step` is ignored while `run`=1.
- Effective length `L` is resolved from `len` each edge.
- Wrap mode:
  - Up: `pos` = L-1 goes to 0, `wrap`=1.
  - Down: `pos` = 0 goes to L-1, `wrap`=1.
  - Otherwise ±1.
- Out-of-range `pos` (`len` shrunk so that `pos` >= L): the next step goes to 0 when up, L-1 when down, with `wrap`=1.
- L=1: `pos` stays 0 and every step asserts `wrap`.
- `value` and `pos` update on the same edge; there is no one-step lag.
- `bcd` is combinational from `value`.
- FSM states:
  - IDLE (`run`=0) → RUN when `run`=1.
  - RUN → IDLE when `run`=0; `pcnt` is cleared in this case.
  - IDLE → IDLE with a step when `step`=1.

## Timing
- All state changes on posedge `clk_500ms`.
- `reset` is asynchronous. Reset values:
  - `pos` = 0
  - `value` = table[0] = 5
  - `bcd` = 0x05
  - `wrap` = 0
  - `pcnt` = 0
  - FSM = IDLE
  - table restored to default contents
  - bounce direction = `up`
- Reset mid-sequence aborts immediately; no partial step.
- Latency:
  - `run` rising to first step: `rate+1` edges.
  - `step` to new `value`: same edge.
  - Write to displayed value: same edge.
- `wrap` is high for exactly the edge interval after the wrapping step.

## Configuration
- `SEQ_PLAYER_PINGPONG_EN` defined:
  - When `pingpong`=1, an internal `dir` register reverses at the ends instead of wrapping.
  - Up at L-1 goes to L-2 and sets `dir`=down; down at 0 goes to 1 and sets `dir`=up. Each reversal asserts `wrap`.
  - When `pingpong`=0, `dir` follows `up` every edge.
  - L=1 holds 0.
- Macro undefined:
  - `pingpong` is ignored and no `dir` register exists.
  - Behaviour is wrap mode only.

## Test plan
- Reset release, `run`=1, `up`=1, `rate`=0, `len`=0 → `value` 10,15,4,9,14,3,8,5; `wrap`=1 on the 5; `bcd` shows 0x10,0x15,0x04…
- `up`=0, `rate`=1 → a step every 2 edges; `pos` 0→7→6, `value` 5→8→3; `wrap` on the 0→7 step.
- `run`=0, `step` pulsed 3 single edges with `up`=1 → `pos` 0→1→2→3, `pcnt` stays 0; `step` with `run`=1 has no extra effect.
- `len`=3 while `pos`=5, `up`=1 → next step `pos`=0 with `wrap`; sequence then cycles 0,1,2,0.
- `wr_en` with `wr_addr`=1, `wr_data`=12 on the edge stepping to `pos`=1 → `value`=12, `bcd`=0x12; table keeps 12 on later passes; reset restores 10.
- Macro on, `pingpong`=1, `len`=4, `up`=1 → `pos` 0,1,2,3,2,1,0,1; `wrap` at the 3→2 and 0→1 reversals. Assert `reset` mid-run → `pos`=0 and `value`=5 immediately.
